// File: rtl/lru_arb_pkg.sv
// Shared types and default sizing for the LRU arbiter.
package lru_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam int N_DEF        = 8;
   localparam int HOLD_MAX_DEF = 16;

endpackage

// File: rtl/lru_arb_pick.sv
// Finds the requesting channel that sits earliest in the LRU order list.
module lru_arb_pick #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0][W-1:0] i_order,
   input  logic [N-1:0]        i_cand,
   output logic [W-1:0]        o_win_idx,
   output logic [W-1:0]        o_win_pos,
   output logic                o_found
);

   logic         w_found;
   logic [W-1:0] w_idx;
   logic [W-1:0] w_pos;

   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_pos   = '0;
      for (int p = 0; p < N; p++) begin
         if (!w_found && i_cand[i_order[p]]) begin
            w_found = 1'b1;
            w_idx   = i_order[p];
            w_pos   = W'(p);
         end
      end
   end

   assign o_win_idx = w_idx;
   assign o_win_pos = w_pos;
   assign o_found   = w_found;

endmodule

// File: rtl/lru_arb.sv
// Least-recently-served arbiter with urgent class and bounded burst lock.
//   state    | meaning
//   ST_IDLE  | no grant outstanding, outputs 0
//   ST_GRANT | one channel owns the grant; hold counter running
module lru_arb
   import lru_arb_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int W        = $clog2(N),
   parameter int HOLD_MAX = HOLD_MAX_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_ena,
   input  logic [N-1:0] i_req,
   input  logic [N-1:0] i_hipri,
   input  logic         i_lock,
   output logic [N-1:0] o_gnt,
   output logic [W-1:0] o_gsel,
   output logic         o_gvalid
);

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

   state_t               r_state, w_state_nxt;
   logic [N-1:0][W-1:0]  r_order, w_order_nxt;
   logic [7:0]           r_cnt, w_cnt_nxt;
   logic [N-1:0]         r_gnt, w_gnt_nxt;
   logic [W-1:0]         r_gsel, w_gsel_nxt;

   logic [N-1:0]         w_urgent;
   logic [N-1:0]         w_cand;
   logic [W-1:0]         w_win_idx;
   logic [W-1:0]         w_win_pos;
   logic                 w_found;
   logic                 w_hold;
   logic                 w_issue;

   assign w_urgent = i_req & i_hipri;
   assign w_cand   = (|w_urgent) ? w_urgent : i_req;

   lru_arb_pick #(.N(N), .W(W)) u_pick (
      .i_order   (r_order),
      .i_cand    (w_cand),
      .o_win_idx (w_win_idx),
      .o_win_pos (w_win_pos),
      .o_found   (w_found)
   );

   assign w_hold  = (r_state == ST_GRANT) && i_lock && i_req[r_gsel] && (r_cnt < HOLD_LIM);
   assign w_issue = !w_hold && i_ena && w_found;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_gnt   <= '0;
         r_gsel  <= '0;
         for (int i = 0; i < N; i++) r_order[i] <= W'(i);
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gnt   <= w_gnt_nxt;
         r_gsel  <= w_gsel_nxt;
         r_order <= w_order_nxt;
      end
   end

   always_comb begin
      w_state_nxt = ST_IDLE;
      if (w_hold || w_issue) w_state_nxt = ST_GRANT;
   end

   // Issuing a grant rotates the winner to the tail; entries behind it close the gap.
   always_comb begin
      w_order_nxt = r_order;
      w_cnt_nxt   = '0;
      w_gnt_nxt   = '0;
      w_gsel_nxt  = '0;
      if (w_hold) begin
         w_cnt_nxt  = r_cnt + 8'd1;
         w_gnt_nxt  = r_gnt;
         w_gsel_nxt = r_gsel;
      end else if (w_issue) begin
         w_cnt_nxt  = 8'd1;
         w_gnt_nxt  = {{(N-1){1'b0}}, 1'b1} << w_win_idx;
         w_gsel_nxt = w_win_idx;
         for (int p = 0; p < N - 1; p++) begin
            if (W'(p) >= w_win_pos) w_order_nxt[p] = r_order[p+1];
         end
         w_order_nxt[N-1] = w_win_idx;
      end
   end

   assign o_gnt    = r_gnt;
   assign o_gsel   = r_gsel;
   assign o_gvalid = |r_gnt;

endmodule

// File: tb/tb_lru_arb.sv
// Directed bench for lru_arb with a queue-based LRU reference model.
module tb_lru_arb;

   localparam int N    = 8;
   localparam int W    = 3;
   localparam int HOLD = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ena = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] hipri = '0;
   logic         lock = 1'b0;
   logic [N-1:0] gnt;
   logic [W-1:0] gsel;
   logic         gvalid;

   int n_checks = 0;
   int n_pass   = 0;

   lru_arb #(.N(N), .HOLD_MAX(HOLD)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_ena    (ena),
      .i_req    (req),
      .i_hipri  (hipri),
      .i_lock   (lock),
      .o_gnt    (gnt),
      .o_gsel   (gsel),
      .o_gvalid (gvalid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
   endtask

   // Reference model: LRU list as a queue, front = least recently served.
   int q[$];
   int m_owner;
   int m_cnt;

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < N; i++) q.push_back(i);
      m_owner = -1;
      m_cnt   = 0;
   endtask

   task automatic model_step();
      logic [N-1:0] cand;
      int           idx;
      cand = ((req & hipri) != 0) ? (req & hipri) : req;
      if (m_owner >= 0 && lock && req[m_owner] && m_cnt < HOLD) begin
         m_cnt++;
      end else if (ena && cand != 0) begin
         idx = -1;
         for (int i = 0; i < q.size(); i++)
            if (idx < 0 && cand[q[i]]) idx = i;
         m_owner = q[idx];
         q.delete(idx);
         q.push_back(m_owner);
         m_cnt = 1;
      end else begin
         m_owner = -1;
         m_cnt   = 0;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   always @(posedge clk or posedge rst) begin
      logic [N-1:0] e_gnt;
      logic [W-1:0] e_gsel;
      #1;
      e_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_gsel = (m_owner >= 0) ? W'(m_owner) : '0;
      check("model_gnt", 32'(gnt), 32'(e_gnt));
      check("model_gsel", 32'(gsel), 32'(e_gsel));
      check("model_gvalid", 32'(gvalid), 32'(m_owner >= 0));
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; hipri = '0; lock = 1'b0; ena = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0;
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_gsel", 32'(gsel), 32'h0);
      check("rst_gvalid", 32'(gvalid), 32'h0);

      // Round robin through all channels under full load
      req = 8'hFF; ena = 1'b1; lock = 1'b0;
      check("rr_latency", 32'(gvalid), 32'h0);
      for (int k = 0; k < 9; k++) begin
         tick();
         check("rr_gsel", 32'(gsel), 32'(k % 8));
         check("rr_gvalid", 32'(gvalid), 32'h1);
      end
      req = '0;
      tick();
      check("rr_idle", 32'(gvalid), 32'h0);

      // Urgent class
      do_reset();
      req = 8'h81; hipri = 8'h80; ena = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("hp_gsel7", 32'(gsel), 32'h7);
      end
      hipri = 8'h00;
      tick();
      check("hp_drop_gsel0", 32'(gsel), 32'h0);
      tick();
      check("hp_next_gsel7", 32'(gsel), 32'h7);
      req = '0; hipri = 8'h7F;
      tick();
      check("hp_noreq_idle", 32'(gvalid), 32'h0);
      hipri = '0;

      // Sole requester under lock: forced release re-grants without bubble
      do_reset();
      req = 8'h08; lock = 1'b1; ena = 1'b1;
      for (int k = 0; k < 7; k++) begin
         tick();
         check("lock_sole_gnt", 32'(gnt), 32'h08);
      end

      // Two requesters under lock: owner releases at HOLD_MAX
      do_reset();
      req = 8'h18; lock = 1'b1; ena = 1'b1;
      for (int k = 0; k < HOLD; k++) begin
         tick();
         check("hold_gsel3", 32'(gsel), 32'h3);
      end
      tick();
      check("hold_release_gsel4", 32'(gsel), 32'h4);

      // Owner drops request mid-burst
      do_reset();
      req = 8'h0C; lock = 1'b1; ena = 1'b1;
      tick();
      check("drop_c1_gsel2", 32'(gsel), 32'h2);
      tick();
      check("drop_c2_gsel2", 32'(gsel), 32'h2);
      req = 8'h08;
      tick();
      check("drop_gsel3", 32'(gsel), 32'h3);
      check("drop_model_tail", 32'(q[N-1]), 32'h3);
      check("drop_model_head", 32'(q[0]), 32'h0);

      // Enable removed during a locked grant
      do_reset();
      req = 8'h20; lock = 1'b1; ena = 1'b1;
      tick();
      check("ena_first_gsel5", 32'(gsel), 32'h5);
      ena = 1'b0;
      for (int k = 0; k < HOLD - 1; k++) begin
         tick();
         check("ena_hold_gvalid", 32'(gvalid), 32'h1);
      end
      tick();
      check("ena_off_gvalid0", 32'(gvalid), 32'h0);
      tick();
      check("ena_off2_gvalid0", 32'(gvalid), 32'h0);
      ena = 1'b1;
      tick();
      check("ena_on_gsel5", 32'(gsel), 32'h5);
      check("ena_on_gvalid", 32'(gvalid), 32'h1);

      // Asynchronous reset mid-grant
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_gnt", 32'(gnt), 32'h0);
      tick();
      rst = 1'b0; req = 8'hFF; lock = 1'b0; ena = 1'b1;
      tick();
      check("post_rst_gsel0", 32'(gsel), 32'h0);
      check("post_rst_gvalid", 32'(gvalid), 32'h1);
      req = '0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lru_arb.md
LRU_ARB -- requirements
Module: lru_arb

Interface
REQ-001 Parameter N, default 8, number of requesting channels (legal 2..32).
REQ-002 Parameter W, default $clog2(N), width of channel index (derived, not overridden).
REQ-003 Parameter HOLD_MAX, default 16, maximum cycles one grant is held under LOCK (legal 1..255).
REQ-004 CLK  input  1  single clock, all state on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 ENA  input  1  arbitration enable; 0 blocks new grants only.
REQ-007 REQ  input  N  per-channel request, level-sensitive.
REQ-008 HIPRI  input  N  per-channel urgent class qualifier, meaningful only with REQ.
REQ-009 LOCK  input  1  current owner requests to keep its grant (burst).
REQ-010 GNT  output  N  one-hot grant, registered.
REQ-011 GSEL  output  W  binary index of granted channel, registered.
REQ-012 GVALID  output  1  grant active, equals |GNT.

Function
REQ-013 Block SHALL keep an LRU order list of N distinct W-bit channel indices; position 0 = least recently served.
REQ-014 Candidate set SHALL be REQ&HIPRI when non-zero, else REQ.
REQ-015 Winner SHALL be the candidate at the lowest order-list position.
REQ-016 FSM SHALL have states IDLE and GRANT.
REQ-017 IDLE: if ENA and candidate set non-zero, winner registered, GNT/GSEL/GVALID asserted next cycle (latency 1), go GRANT; else stay IDLE, outputs 0.
REQ-018 On every grant issue, winner SHALL move to tail (position N-1); entries behind it shift one position toward 0; entries ahead unchanged.
REQ-019 GRANT: hold counter SHALL start at 1 on grant issue and increment each held cycle.
REQ-020 Grant SHALL be held while LOCK=1, REQ[GSEL]=1 and counter < HOLD_MAX.
REQ-021 Release SHALL occur when LOCK=0, REQ[GSEL]=0, or counter = HOLD_MAX.
REQ-022 On release with ENA=1 and non-zero candidate set, new winner SHALL be granted in the next cycle with no idle bubble (FSM stays GRANT, counter reloads 1).
REQ-023 On release otherwise, FSM SHALL go IDLE and outputs SHALL be 0 next cycle.
REQ-024 With LOCK=0, each grant SHALL last exactly one cycle.
REQ-025 Forced release at HOLD_MAX with owner as sole requester SHALL re-grant the owner (fresh counter).
REQ-026 ENA=0 during GRANT SHALL not shorten the current grant; only the subsequent re-arbitration is blocked.
REQ-027 Order list SHALL remain a permutation of 0..N-1 at all times.
REQ-028 HIPRI without REQ SHALL be ignored.

Reset
REQ-029 RST=1 SHALL asynchronously set order list to identity (position i holds i), state IDLE, counter 0, GNT=0, GSEL=0, GVALID=0.
REQ-030 Reset mid-grant SHALL drop GNT immediately; first grant after release follows identity order.

Structure
REQ-031 Package lru_arb_pkg SHALL hold the FSM state enum and default N/HOLD_MAX constants.
REQ-032 Sub-module lru_arb_pick SHALL implement the combinational first-candidate-in-order search (order list, candidate mask in; winner index, winner position, found out).

Verification (N=8, HOLD_MAX=4)
REQ-033 After reset, REQ=8'hFF, LOCK=0, ENA=1 continuous -> GSEL 0,1,2,...,7,0 on consecutive cycles, first grant one cycle after REQ.
REQ-034 REQ=8'h81, HIPRI=8'h80 -> channel 7 granted repeatedly while HIPRI held; channel 0 granted once HIPRI drops.
REQ-035 REQ[3]=1 only, LOCK=1 -> GNT=8'h08 held 4 cycles, forced release, re-granted to 3 without bubble.
REQ-036 REQ=8'h0C, LOCK=1, channel 2 owns, REQ[2] drops on cycle 2 -> channel 3 granted next cycle; order tail = 3.
REQ-037 ENA=0 while channel 5 granted with LOCK=1 -> grant completes normally, then GVALID=0 until ENA=1.
REQ-038 RST pulse mid-grant -> GNT=0 same cycle; next grant with REQ=8'hFF is channel 0.
